// File: rtl/feeder_pkg.sv
// Shared types and helpers for the systolic row feeder.
package feeder_pkg;

  localparam int unsigned DefaultIntBits = 13;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StShiftW,
    StLatch,
    StStream,
    StFlush
  } feeder_state_e;

  // Low bit of row slice idx in a packed vector of width-bit elements.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Per-row delay line: DEPTH skew stages followed by the registered row output.
// The output register can be loaded directly (weight shift) or cleared with the skew stages.
module skew_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_pipe [DEPTH+1];
  logic [DEPTH:0]   r_vld;
  logic [WIDTH-1:0] w_src  [DEPTH+1];
  logic [DEPTH:0]   w_vsrc;

  assign w_src[0]  = i_data;
  assign w_vsrc[0] = i_valid;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_src
    assign w_src[k]  = r_pipe[k-1];
    assign w_vsrc[k] = r_vld[k-1];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k <= int'(DEPTH); k++) begin
        r_pipe[k] <= '0;
      end
      r_vld <= '0;
    end else begin
      for (int k = 0; k <= int'(DEPTH); k++) begin
        r_pipe[k] <= i_clear ? '0 : w_src[k];
        r_vld[k]  <= i_clear ? 1'b0 : w_vsrc[k];
      end
      // A direct load only ever targets the output stage.
      if (i_load) begin
        r_pipe[DEPTH] <= i_load_data;
        r_vld[DEPTH]  <= 1'b0;
      end
    end
  end

  assign o_data  = r_pipe[DEPTH];
  assign o_valid = r_vld[DEPTH];

endmodule

// File: rtl/systolic_row_feeder.sv
// Row feeder for the PE array: loads and aligns a weight tile, strobes weight_en,
// then streams activation vectors with an r-cycle skew on row r.
module systolic_row_feeder
  import feeder_pkg::*;
#(
  parameter int unsigned INT_BITS = DefaultIntBits,
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_reuse_w,
  input  logic                     i_w_valid,
  output logic                     o_w_ready,
  input  logic [ROWS*INT_BITS-1:0] i_w_data,
  input  logic                     i_a_valid,
  output logic                     o_a_ready,
  input  logic                     i_a_last,
  input  logic [ROWS*INT_BITS-1:0] i_a_data,
  output logic [ROWS*INT_BITS-1:0] o_row_ele,
  output logic [ROWS-1:0]          o_row_valid,
  output logic                     o_weight_en,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int unsigned CntMax = max_u(ROWS, COLS);
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned IdxW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CntW-1:0] ColsLast  = CntW'(COLS - 1);
  localparam logic [CntW-1:0] FlushLast = CntW'((ROWS > 1) ? ROWS - 2 : 0);

  feeder_state_e r_state, w_state_d;
  logic [CntW-1:0]          r_cnt;
  logic [ROWS*INT_BITS-1:0] r_buf [COLS];
  logic                     r_done, w_done_d;
  logic                     r_weight_en;
  logic                     w_w_acc, w_a_acc;
  logic [IdxW-1:0]          w_wr_idx, w_rd_idx;
  logic [ROWS*INT_BITS-1:0] w_shift_word, w_inj;
  logic                     w_skew_clear, w_skew_load;

  assign w_w_acc = i_w_valid && (r_state == StLoadW);
  assign w_a_acc = i_a_valid && (r_state == StStream);

  always_comb begin
    w_state_d = r_state;
    w_done_d  = 1'b0;
    unique case (r_state)
      StIdle:   if (i_start) w_state_d = i_reuse_w ? StStream : StLoadW;
      StLoadW:  if (w_w_acc && (r_cnt == ColsLast)) w_state_d = StShiftW;
      StShiftW: if (r_cnt == ColsLast) w_state_d = StLatch;
      StLatch:  w_state_d = StStream;
      StStream: begin
        if (w_a_acc && i_a_last) begin
          if (ROWS == 1) begin
            w_state_d = StIdle;
            w_done_d  = 1'b1;
          end else begin
            w_state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (r_cnt == FlushLast) begin
          w_state_d = StIdle;
          w_done_d  = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_done  <= w_done_d;
      if (w_state_d != r_state) begin
        r_cnt <= '0;
      end else if (w_w_acc || (r_state == StShiftW) || (r_state == StFlush)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_wr_idx = IdxW'(r_cnt);
  // Last column goes out first so column c holds buf[c] once the shift completes.
  assign w_rd_idx = IdxW'(ColsLast - r_cnt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < int'(COLS); k++) begin
        r_buf[k] <= '0;
      end
    end else if (w_w_acc) begin
      r_buf[w_wr_idx] <= i_w_data;
    end
  end

  // Strobe rises mid-LATCH and falls mid-way through the following cycle.
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_weight_en <= 1'b0;
    end else begin
      r_weight_en <= (r_state == StLatch);
    end
  end

  assign w_shift_word = r_buf[w_rd_idx];
  assign w_inj        = w_a_acc ? i_a_data : '0;
  assign w_skew_load  = (r_state == StShiftW);
  assign w_skew_clear = (r_state != StStream) && (r_state != StFlush);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    skew_delay_line #(
      .DEPTH (r),
      .WIDTH (INT_BITS)
    ) u_skew (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_clear     (w_skew_clear),
      .i_load      (w_skew_load),
      .i_load_data (w_shift_word[slice_lo(r, INT_BITS) +: INT_BITS]),
      .i_valid     (w_a_acc),
      .i_data      (w_inj[slice_lo(r, INT_BITS) +: INT_BITS]),
      .o_valid     (o_row_valid[r]),
      .o_data      (o_row_ele[slice_lo(r, INT_BITS) +: INT_BITS])
    );
  end

  assign o_w_ready   = (r_state == StLoadW);
  assign o_a_ready   = (r_state == StStream);
  assign o_busy      = (r_state != StIdle);
  assign o_done      = r_done;
  assign o_weight_en = r_weight_en;

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Self-checking bench for systolic_row_feeder: job-level model plus directed literal checks.
module tb_systolic_row_feeder;

  localparam int IB = 13;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int P_IDLE = 0, P_LOAD = 1, P_SHIFT = 2, P_LATCH = 3, P_STREAM = 4, P_FLUSH = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, reuse_w = 1'b0, w_valid = 1'b0, a_valid = 1'b0, a_last = 1'b0;
  logic [R*IB-1:0] w_data = '0, a_data = '0;
  logic w_ready, a_ready, weight_en, busy, done;
  logic [R*IB-1:0] row_ele;
  logic [R-1:0] row_valid;

  systolic_row_feeder #(.INT_BITS(IB), .ROWS(R), .COLS(C)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_reuse_w   (reuse_w),
    .i_w_valid   (w_valid),
    .o_w_ready   (w_ready),
    .i_w_data    (w_data),
    .i_a_valid   (a_valid),
    .o_a_ready   (a_ready),
    .i_a_last    (a_last),
    .i_a_data    (a_data),
    .o_row_ele   (row_ele),
    .o_row_valid (row_valid),
    .o_weight_en (weight_en),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;

  function automatic int elem(input logic [R*IB-1:0] v, input int r);
    return int'(v[r*IB +: IB]);
  endfunction

  // Vector whose row r element is e0 + r.
  function automatic logic [R*IB-1:0] vec(input int e0);
    logic [R*IB-1:0] v;
    v = '0;
    for (int r = 0; r < R; r++) v[r*IB +: IB] = IB'(e0 + r);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- job-level model ----------------
  int ph = P_IDLE, ph_prev = P_IDLE;
  int nbeat = 0, nshift = 0, nflush = 0;
  int mbuf [C][R];
  int inj_e [8][R];
  bit inj_v [8];
  int exp_ele [R];
  bit exp_v [R];
  bit exp_done = 1'b0;
  bit m_acc;
  int slot, back;

  initial forever begin : model
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      ph = P_IDLE; ph_prev = P_IDLE; exp_done = 1'b0;
      nbeat = 0; nshift = 0; nflush = 0;
      for (int i = 0; i < 8; i++) begin
        inj_v[i] = 1'b0;
        for (int r = 0; r < R; r++) inj_e[i][r] = 0;
      end
      for (int r = 0; r < R; r++) begin
        exp_ele[r] = 0; exp_v[r] = 1'b0;
        for (int c = 0; c < C; c++) mbuf[c][r] = 0;
      end
    end else begin
      m_acc = (ph == P_STREAM) && a_valid;
      slot  = cyc % 8;
      inj_v[slot] = m_acc;
      for (int r = 0; r < R; r++) inj_e[slot][r] = m_acc ? elem(a_data, r) : 0;
      // Row r shows what was injected r edges ago, except during the unskewed weight shift.
      for (int r = 0; r < R; r++) begin
        if (ph == P_SHIFT) begin
          exp_ele[r] = mbuf[C-1-nshift][r];
          exp_v[r]   = 1'b0;
        end else begin
          back       = (cyc + 8 - r) % 8;
          exp_ele[r] = inj_e[back][r];
          exp_v[r]   = inj_v[back];
        end
      end
      exp_done = 1'b0;
      ph_prev  = ph;
      case (ph)
        P_IDLE: if (start) begin ph = reuse_w ? P_STREAM : P_LOAD; nbeat = 0; end
        P_LOAD: if (w_valid) begin
          for (int r = 0; r < R; r++) mbuf[nbeat][r] = elem(w_data, r);
          nbeat++;
          if (nbeat == C) begin ph = P_SHIFT; nshift = 0; end
        end
        P_SHIFT: begin nshift++; if (nshift == C) ph = P_LATCH; end
        P_LATCH: ph = P_STREAM;
        P_STREAM: if (m_acc && a_last) begin
          if (R == 1) begin ph = P_IDLE; exp_done = 1'b1; end
          else begin ph = P_FLUSH; nflush = 0; end
        end
        P_FLUSH: begin nflush++; if (nflush == R - 1) begin ph = P_IDLE; exp_done = 1'b1; end end
        default: ph = P_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [R*IB-1:0] e_ele;
  logic [R-1:0] e_v;

  initial forever begin : compare
    @(posedge clk); #3;
    e_ele = '0; e_v = '0;
    if (rst_n) for (int r = 0; r < R; r++) begin
      e_ele[r*IB +: IB] = IB'(exp_ele[r]);
      e_v[r] = exp_v[r];
    end
    chk("row_ele", row_ele, e_ele);
    chk("row_valid", row_valid, e_v);
    chk("w_ready", w_ready, rst_n && (ph == P_LOAD));
    chk("a_ready", a_ready, rst_n && (ph == P_STREAM));
    chk("busy", busy, rst_n && (ph != P_IDLE));
    chk("done", done, rst_n && exp_done);
    chk("weight_en_early", weight_en, rst_n && (ph_prev == P_LATCH));
    @(negedge clk); #3;
    chk("weight_en_late", weight_en, rst_n && (ph == P_LATCH));
  end

  // ---------------- stimulus helpers ----------------
  int ring_e [16][R];
  bit ring_v [16][R];
  int wr_seen = 0, we_rises = 0, ph_at_rise = -1;
  int k0, s0, lat;

  always @(posedge weight_en) begin
    we_rises++;
    ph_at_rise = ph;
  end

  task automatic step();
    @(posedge clk); #1;
    for (int r = 0; r < R; r++) begin
      ring_e[cyc % 16][r] = elem(row_ele, r);
      ring_v[cyc % 16][r] = row_valid[r];
    end
    if (w_ready) wr_seen++;
  endtask

  task automatic wait_ph(input int p, input int budget);
    int n;
    n = 0;
    while (ph != p && n < budget) begin step(); n++; end
    checks++;
    if (ph != p) begin
      failures++;
      $display("FAIL wait_phase cyc=%0d actual=%0d required=%0d", cyc, ph, p);
    end
  endtask

  task automatic load_beats(input int base, input bit gaps);
    start = 1'b1; reuse_w = 1'b0;
    step();
    start = 1'b0;
    for (int c = 0; c < C; c++) begin
      w_valid = 1'b1; w_data = vec(base + 10 * c);
      step();
      w_valid = 1'b0;
      if (gaps) step();
    end
  endtask

  // In the LATCH cycle, column c sees the row output from c cycles earlier.
  task automatic check_taps(input int base);
    wait_ph(P_LATCH, 20);
    lat = cyc;
    for (int c = 0; c < C; c++)
      for (int r = 0; r < R; r++)
        chk($sformatf("tap_c%0d_r%0d", c, r), ring_e[(lat - c + 16) % 16][r], base + 10 * c + r);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_row_ele", row_ele, 0);
    chk("rst_busy", busy, 0);
    chk("rst_weight_en", weight_en, 0);
    rst_n = 1'b1;
    step();

    // Job 1: weight load with gaps, back-to-back vectors.
    load_beats(0, 1'b1);
    check_taps(0);
    wait_ph(P_STREAM, 5);
    k0 = cyc;
    a_valid = 1'b1; a_data = vec(1); a_last = 1'b0;
    step();
    chk("skew_row0_first", elem(row_ele, 0), 1);
    chk("skew_row0_valid", row_valid[0], 1);
    a_data = vec(5); a_last = 1'b1;
    step();
    chk("skew_row0_second", elem(row_ele, 0), 5);
    a_valid = 1'b0; a_last = 1'b0;
    step(); step();
    chk("skew_row3_first", elem(row_ele, 3), 4);
    chk("skew_row3_valid", row_valid[3], 1);
    step();
    chk("skew_row3_second", elem(row_ele, 3), 8);
    chk("done_after_flush", done, 1);
    chk("skew_cycle_span", cyc - k0, 5);
    wait_ph(P_IDLE, 10);
    chk("weight_en_rises", we_rises, 1);
    chk("weight_en_rise_phase", ph_at_rise, P_LATCH);

    // Job 2: reuse weights, two bubbles, start pulsed mid-stream.
    wr_seen = 0;
    step();
    start = 1'b1; reuse_w = 1'b1; s0 = cyc;
    step();
    start = 1'b0;
    chk("reuse_direct_stream", a_ready, 1);
    a_valid = 1'b1; a_data = vec(11);
    step();
    a_valid = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0; reuse_w = 1'b0;
    a_valid = 1'b1; a_data = vec(15); a_last = 1'b1;
    step();
    a_valid = 1'b0; a_last = 1'b0;
    wait_ph(P_IDLE, 10);
    chk("bubble_row2_a", ring_e[(s0 + 4) % 16][2], 13);
    chk("bubble_row2_b1", {ring_e[(s0 + 5) % 16][2], 31'(ring_v[(s0 + 5) % 16][2])}, 0);
    chk("bubble_row2_b2", {ring_e[(s0 + 6) % 16][2], 31'(ring_v[(s0 + 6) % 16][2])}, 0);
    chk("bubble_row2_b", ring_e[(s0 + 7) % 16][2], 17);
    chk("bubble_row2_bv", ring_v[(s0 + 7) % 16][2], 1);
    chk("reuse_no_w_ready", wr_seen, 0);
    chk("reuse_no_weight_en", we_rises, 1);

    // Job 3: reset after two shift edges, then a clean reload.
    step();
    load_beats(100, 1'b0);
    wait_ph(P_SHIFT, 5);
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("midrst_row_ele", row_ele, 0);
    chk("midrst_row_valid", row_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_weight_en", weight_en, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("postrst_idle", busy, 0);
    load_beats(200, 1'b1);
    check_taps(200);
    wait_ph(P_STREAM, 5);
    a_valid = 1'b1; a_data = vec(40); a_last = 1'b1;
    step();
    a_valid = 1'b0; a_last = 1'b0;
    wait_ph(P_IDLE, 10);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_row_feeder.md
Name: systolic_row_feeder

Overview:
Transmit side of the PE array's horizontal element path. Buffers one COLS-deep weight tile and shifts it into the array with correct column alignment, then generates the shared weight_en latch strobe. Afterwards it streams activation vectors into the ROWS row inputs with a diagonal skew of r cycles on row r, so activations line up with the psum wavefront flowing down the array. Sits between the tile loader and column 0 of the PE array.

Parameters:
INT_BITS, 13, width of every element; matches the PE int_bits.
ROWS, 4, number of array rows, which is also the activation vector length.
COLS, 4, number of array columns, which is also the weight beats per tile.

Ports:
clk  input  1  single clock, rising-edge logic except the weight_en generator.
reset  input  1  asynchronous, active-low (reset asserted when 0); clears all state.
start  input  1  starts a job; sampled only in IDLE.
reuse_w  input  1  sampled with start; 1 skips weight load and keeps the weights already in the array.
w_valid  input  1  weight beat valid.
w_ready  output  1  weight beat accepted when w_valid & w_ready.
w_data  input  ROWS*INT_BITS  weights for one column, all rows; row r is in slice r; beats arrive as column 0 first.
a_valid  input  1  activation vector valid.
a_ready  output  1  activation accepted when a_valid & a_ready.
a_last  input  1  marks the final vector of the job.
a_data  input  ROWS*INT_BITS  activation vector; element r goes to row r.
row_ele  output  ROWS*INT_BITS  registered drive to the in_ele input of each row's column-0 PE.
row_valid  output  ROWS  skewed valid tag per row, for the downstream collector.
weight_en  output  1  weight latch strobe to all PEs.
busy  output  1  high whenever the block is not in IDLE.
done  output  1  one-cycle pulse at job end.

Behaviour:
- Reset values: w_ready=0, a_ready=0, row_ele=0, row_valid=0, weight_en=0, busy=0, done=0; tile buffer, skew lines and counters all 0; state=IDLE.
- State IDLE: on start, go to LOAD_W if reuse_w=0, otherwise go to STREAM.
- State LOAD_W: w_ready=1. Beat k writes buf[k]. After COLS accepted beats, go to SHIFT_W. Gaps in w_valid are allowed and have no effect on the array.
- State SHIFT_W: lasts exactly COLS cycles with no gaps. On the j-th edge (j=0..COLS-1), all rows of row_ele load buf[COLS-1-j] with no skew. row_valid=0. Then go to LATCH.
- Alignment rule: in the LATCH cycle, column c's in_ele equals buf[c] for every row.
- State LATCH: lasts 1 cycle. weight_en comes from a falling-edge flop that samples state==LATCH. It rises mid-LATCH and falls one period later, so the strobe edge lands while in_ele is stable. Then go to STREAM with the skew lines cleared.
- State STREAM: a_ready=1. An element accepted at edge T appears on row r's row_ele after edge T+r, with row_valid[r]=1 for that cycle. A cycle without an accept injects 0 with row_valid=0 (a bubble). Accepting with a_last=1 moves to FLUSH.
- State FLUSH: lasts ROWS-1 cycles of zero bubbles so the skew lines drain; a_ready=0. At the end, done=1 for 1 cycle and the state returns to IDLE.
- Simultaneous events: start outside IDLE is ignored. If ROWS=1, FLUSH is 0 cycles and done pulses on the cycle after the a_last accept.
- Elements pass through unmodified; no arithmetic is performed and the width stays INT_BITS.
- Reset asserted mid-operation clears everything immediately, including weight_en. Weights already latched in the PEs are not this block's concern.

Decomposition:
- feeder_pkg: state enum (IDLE, LOAD_W, SHIFT_W, LATCH, STREAM, FLUSH); default INT_BITS; a helper for row-slice indexing.
- Sub-module skew_delay_line (parameters DEPTH and WIDTH, with clear input): instantiated once per row with DEPTH=r. For row 0, DEPTH=0 means a direct register.

Test Plan:
- Weight load, ROWS=COLS=4: beats col0..col3 with w_data[r]=10*c+r, gaps between beats. Required: SHIFT_W drives row0 with 30,20,10,0; during LATCH, a column tap model sees column c row r = 10*c+r; weight_en rises once, mid-LATCH.
- Skew: stream vectors {1,2,3,4}, {5,6,7,8} back-to-back then a_last. Required: row0 shows 1,5 in consecutive cycles; row3 shows 4 then 8 starting 3 cycles after row0's 1; row_valid tracks exactly those cycles; done fires 3 cycles after the last accept.
- Bubbles: a_valid low for 2 cycles between vectors. Required: each row shows two 0s with row_valid=0 at its skewed position, and data order is preserved.
- Weight reuse: start with reuse_w=1. Required: direct transition IDLE->STREAM; w_ready never asserted; weight_en stays 0.
- Reset mid-SHIFT_W (reset=0 after 2 shifts). Required: all outputs return to 0 immediately; after release the state is IDLE; a new start reloads the tile correctly.
- Start ignored: pulse start during STREAM. Required: no state change and the job completes normally.
